game_sequencer: RTL and testbench

- Top-level controller for the minesweeper cell array.
- Places NUM_MINES mines pseudo-randomly, always leaving one player-chosen safe cell mine-free.
- Clears the cell array, opens play, and detects win/loss from the per-cell status lines.
- Runs a saturating seconds timer for the display; sits between the input/UI logic and the array of per-cell blocks.

---
 rtl/game_sequencer_pkg.sv | 14 +
 rtl/game_sequencer_if.sv | 27 ++
 rtl/game_sequencer_lfsr16.sv | 16 +
 rtl/game_sequencer.sv | 131 +++++++++++++
 tb/tb_game_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the minesweeper game sequencer.
package game_sequencer_pkg;

   typedef enum logic [2:0] {IDLE, PLACE, PLAY, WON, LOST} game_state_t;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS   = 16'hB400;
   localparam logic [9:0]  SECONDS_MAX = 10'd999;

   function automatic logic lfsr_feedback(input logic [15:0] value);
      return ^(value & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Handshake and status bundle between the UI logic, the sequencer and the cell array.
interface game_sequencer_if #(
   parameter int CELLS = 64,
   parameter int IDX_W = 6
);
   logic             start;
   logic [IDX_W-1:0] safe_idx;
   logic [CELLS-1:0] block_won;
   logic [CELLS-1:0] block_lost;
   logic [CELLS-1:0] init_mine;
   logic             playing;
   logic             board_rst_n;
   logic             game_won;
   logic             game_lost;
   logic             busy;
   logic [9:0]       seconds;

   modport master (
      output start, safe_idx, block_won, block_lost,
      input  init_mine, playing, board_rst_n, game_won, game_lost, busy, seconds
   );

   modport slave (
      input  start, safe_idx, block_won, block_lost,
      output init_mine, playing, board_rst_n, game_won, game_lost, busy, seconds
   );
endinterface

// File: rtl/game_sequencer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads its seed while reset is low.
module game_sequencer_lfsr16
   import game_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   always_ff @(posedge clk) begin
      if (!reset) value <= seed;
      else        value <= {value[14:0], lfsr_feedback(value)};
   end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: random mine placement around a safe cell, play supervision,
// win/loss detection and a saturating seconds timer.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int          CELLS         = 64,
   parameter int          IDX_W         = 6,
   parameter int          NUM_MINES     = 10,
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          TICKS_PER_SEC = 50_000_000
)(
   input logic            clk,
   input logic            reset,
   game_sequencer_if.slave bus
);

   if (CELLS < 2 || CELLS > 65535) begin : g_bad_cells
      $error("game_sequencer: CELLS must be 2..65535");
   end
   if ((2 ** IDX_W) < CELLS) begin : g_bad_idx_w
      $error("game_sequencer: IDX_W too narrow for CELLS");
   end
   if (NUM_MINES < 1 || NUM_MINES > CELLS - 1) begin : g_bad_mines
      $error("game_sequencer: NUM_MINES must be 1..CELLS-1");
   end
   if (SEED == 16'd0) begin : g_bad_seed
      $error("game_sequencer: SEED must be non-zero");
   end
   if (TICKS_PER_SEC < 1) begin : g_bad_ticks
      $error("game_sequencer: TICKS_PER_SEC must be positive");
   end

   localparam int unsigned     CW         = IDX_W + 1;
   localparam logic [CW-1:0]   CELLS_V    = CW'(CELLS);
   localparam logic [15:0]     MINES_LAST = 16'(NUM_MINES - 1);
   localparam int unsigned     TICK_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

   game_state_t       state;
   logic [15:0]       lfsr_value;
   logic              lfsr_unused;
   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  safe_lat;
   logic [15:0]       mine_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic              first_play;
   logic              accept;

   game_sequencer_lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .value (lfsr_value)
   );

   assign cand        = lfsr_value[IDX_W-1:0];
   assign lfsr_unused = ^(lfsr_value >> IDX_W);
   assign accept      = ({1'b0, cand} < CELLS_V) && (cand != safe_lat) && !bus.init_mine[cand];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= IDLE;
         bus.init_mine   <= '0;
         bus.playing     <= 1'b0;
         bus.board_rst_n <= 1'b1;
         bus.game_won    <= 1'b0;
         bus.game_lost   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.seconds     <= '0;
         tick_cnt        <= '0;
         mine_cnt        <= '0;
         first_play      <= 1'b0;
      end else begin
         case (state)
            IDLE, WON, LOST: begin
               if (bus.start) begin
                  state           <= PLACE;
                  safe_lat        <= bus.safe_idx;
                  bus.init_mine   <= '0;
                  mine_cnt        <= '0;
                  bus.game_won    <= 1'b0;
                  bus.game_lost   <= 1'b0;
                  bus.seconds     <= '0;
                  tick_cnt        <= '0;
                  bus.busy        <= 1'b1;
                  bus.board_rst_n <= 1'b0;
               end
            end

            PLACE: begin
               if (accept) begin
                  bus.init_mine[cand] <= 1'b1;
                  mine_cnt            <= mine_cnt + 16'd1;
                  if (mine_cnt == MINES_LAST) begin
                     state           <= PLAY;
                     bus.busy        <= 1'b0;
                     bus.board_rst_n <= 1'b1;
                     bus.playing     <= 1'b1;
                     first_play      <= 1'b1;
                  end
               end
            end

            PLAY: begin
               first_play <= 1'b0;
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  if (bus.seconds != SECONDS_MAX) bus.seconds <= bus.seconds + 10'd1;
               end else begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
               // Cells are still leaving reset on the first PLAY cycle
               if (!first_play) begin
                  if (|bus.block_lost) begin
                     state         <= LOST;
                     bus.playing   <= 1'b0;
                     bus.game_lost <= 1'b1;
                  end else if (&bus.block_won) begin
                     state         <= WON;
                     bus.playing   <= 1'b0;
                     bus.game_won  <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a 64-cell instance and a 9-cell instance.
module tb_game_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   game_sequencer_if #(.CELLS(64), .IDX_W(6)) ifa ();
   game_sequencer_if #(.CELLS(9),  .IDX_W(4)) ifb ();

   game_sequencer #(
      .CELLS(64), .IDX_W(6), .NUM_MINES(10), .SEED(16'hACE1), .TICKS_PER_SEC(4)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   game_sequencer #(
      .CELLS(9), .IDX_W(4), .NUM_MINES(8), .SEED(16'hACE1), .TICKS_PER_SEC(4)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   typedef struct {
      logic [63:0] won;
      logic [63:0] lost;
      logic [5:0]  sidx;
      logic        exp_won;
      logic        exp_lost;
   } vec_t;

   vec_t vecs [5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int popcount64(input logic [63:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 64; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic start_a(input logic [5:0] sidx);
      ifa.safe_idx = sidx;
      ifa.start    = 1'b1;
      step();
      ifa.start    = 1'b0;
      check("busy_after_start", {ifa.busy, ifa.board_rst_n, ifa.playing}, 3'b100);
      check("flags_clear", {ifa.game_won, ifa.game_lost}, 2'b00);
      check("seconds_clear", ifa.seconds, 0);
      check("map_clear", ifa.init_mine, 0);
   endtask

   task automatic place_a(input logic [5:0] sidx);
      int n;
      int bad;
      int prev_pop;
      n = 0;
      bad = 0;
      prev_pop = 0;
      while (ifa.playing !== 1'b1 && n < 2000) begin
         if (ifa.busy !== 1'b1 || ifa.board_rst_n !== 1'b0) bad++;
         prev_pop = popcount64(ifa.init_mine);
         step();
         n++;
      end
      check("place_timeout", n < 2000, 1);
      check("place_busy_brst", bad, 0);
      check("place_prev_pop", prev_pop, 9);
      check("mine_count", popcount64(ifa.init_mine), 10);
      check("safe_cell", ifa.init_mine[sidx], 0);
      check("play_entry", {ifa.busy, ifa.board_rst_n}, 2'b01);
   endtask

   initial begin
      logic [63:0] map0;
      int          n;
      int          ck_k   [7];
      int          ck_sec [7];

      vecs[0] = '{won: 64'h0,                lost: 64'h20,               sidx: 6'd27, exp_won: 1'b0, exp_lost: 1'b1};
      vecs[1] = '{won: 64'hFFFF_FFFF_FFFF_FFFF, lost: 64'h0,             sidx: 6'd0,  exp_won: 1'b1, exp_lost: 1'b0};
      vecs[2] = '{won: 64'hFFFF_FFFF_FFFF_FFFF, lost: 64'h1,             sidx: 6'd63, exp_won: 1'b0, exp_lost: 1'b1};
      vecs[3] = '{won: 64'h7FFF_FFFF_FFFF_FFFF, lost: 64'h0,             sidx: 6'd5,  exp_won: 1'b0, exp_lost: 1'b0};
      vecs[4] = '{won: 64'h0,                lost: 64'h8000_0000_0000_0000, sidx: 6'd40, exp_won: 1'b0, exp_lost: 1'b1};

      ck_k   = '{3, 4, 7, 8, 3995, 3996, 4100};
      ck_sec = '{0, 1, 1, 2, 998,  999,  999};

      ifa.start = 1'b1; ifa.safe_idx = 6'd27; ifa.block_won = '0; ifa.block_lost = '0;
      ifb.start = 1'b1; ifb.safe_idx = 4'd0;  ifb.block_won = '0; ifb.block_lost = '0;

      // Reset with start held high
      reset = 1'b0;
      step();
      step();
      check("rst_init_mine", ifa.init_mine, 0);
      check("rst_playing", ifa.playing, 0);
      check("rst_board_rst_n", ifa.board_rst_n, 1);
      check("rst_flags", {ifa.game_won, ifa.game_lost}, 2'b00);
      check("rst_busy", ifa.busy, 0);
      check("rst_seconds", ifa.seconds, 0);
      check("rst_b_outputs", {ifb.init_mine, ifb.busy, ifb.playing, ifb.board_rst_n}, {9'h0, 3'b001});
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      reset = 1'b1;
      step();
      step();
      step();
      check("idle_after_release", {ifa.busy, ifa.playing, ifb.busy, ifb.playing}, 4'b0000);

      // Loss after ten PLAY cycles, then display values held
      start_a(6'd27);
      place_a(6'd27);
      map0 = ifa.init_mine;
      for (int k = 1; k <= 9; k++) step();
      ifa.block_lost = 64'h20;
      step();
      check("loss_flags", {ifa.game_won, ifa.game_lost, ifa.playing}, 3'b010);
      check("loss_seconds", ifa.seconds, 2);
      ifa.block_lost = '0;
      for (int k = 0; k < 8; k++) step();
      check("hold_seconds", ifa.seconds, 2);
      check("hold_map", ifa.init_mine, map0);
      check("hold_lost", {ifa.game_lost, ifa.playing}, 2'b10);

      // Table of win/loss patterns, each game started straight from WON/LOST
      for (int i = 0; i < 5; i++) begin
         start_a(vecs[i].sidx);
         place_a(vecs[i].sidx);
         ifa.block_won  = vecs[i].won;
         ifa.block_lost = vecs[i].lost;
         step();
         check($sformatf("vec%0d_first_ignored", i), {ifa.playing, ifa.game_won, ifa.game_lost}, 3'b100);
         step();
         check($sformatf("vec%0d_flags", i), {ifa.game_won, ifa.game_lost},
               {vecs[i].exp_won, vecs[i].exp_lost});
         check($sformatf("vec%0d_playing", i), ifa.playing, !(vecs[i].exp_won || vecs[i].exp_lost));
         if (!vecs[i].exp_won && !vecs[i].exp_lost) begin
            ifa.block_won  = '0;
            ifa.block_lost = 64'h1;
            step();
            check($sformatf("vec%0d_forced_loss", i), {ifa.game_lost, ifa.playing}, 2'b10);
         end
         ifa.block_won  = '0;
         ifa.block_lost = '0;
         step();
         step();
         check($sformatf("vec%0d_sticky", i), {ifa.game_won, ifa.game_lost},
               {vecs[i].exp_won, !vecs[i].exp_won});
      end

      // Reset in the middle of play aborts without a flag
      start_a(6'd10);
      place_a(6'd10);
      step();
      step();
      step();
      ifa.block_lost = '1;
      reset = 1'b0;
      step();
      check("abort_outputs", {ifa.playing, ifa.busy, ifa.board_rst_n, ifa.game_won, ifa.game_lost}, 5'b00100);
      check("abort_map", ifa.init_mine, 0);
      check("abort_seconds", ifa.seconds, 0);
      reset = 1'b1;
      ifa.block_lost = '0;
      step();
      check("abort_idle", {ifa.playing, ifa.busy, ifa.game_lost}, 3'b000);

      // Seconds timer: one second per 4 PLAY cycles, saturating at 999
      start_a(6'd27);
      place_a(6'd27);
      for (int k = 1; k <= 4100; k++) begin
         step();
         for (int c = 0; c < 7; c++) begin
            if (ck_k[c] == k) check($sformatf("seconds_at_%0d", k), ifa.seconds, ck_sec[c]);
         end
      end
      check("timer_still_playing", ifa.playing, 1);

      // 9-cell board: every cell except the safe one must end up mined
      ifb.safe_idx = 4'd0;
      ifb.start    = 1'b1;
      step();
      check("b_busy_after_start", {ifb.busy, ifb.board_rst_n}, 2'b10);
      step();
      step();
      ifb.start = 1'b0;
      n = 0;
      while (ifb.playing !== 1'b1 && n < 5000) begin
         step();
         n++;
      end
      check("b_place_timeout", n < 5000, 1);
      check("b_mine_map", ifb.init_mine, 9'b111111110);
      check("b_play_entry", {ifb.busy, ifb.board_rst_n}, 2'b01);
      ifb.start = 1'b1;
      step();
      ifb.start = 1'b0;
      step();
      check("b_start_ignored_in_play", {ifb.playing, ifb.busy, ifb.init_mine}, {2'b10, 9'b111111110});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
